// File: rtl/food_placer.sv
// rtl/food_placer.sv - picks a free, in-field food cell from random samples with a raster-scan fallback
module food_placer #(
  parameter int H_MAX     = 160,
  parameter int V_MAX     = 120,
  parameter int MAX_TRIES = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       REQ,
  input  logic [1:0] MASTER_STATE,
  input  logic [7:0] RAND_HORZ,
  input  logic [6:0] RAND_VERT,
  output logic       QUERY_VALID,
  output logic [7:0] QUERY_HORZ,
  output logic [6:0] QUERY_VERT,
  input  logic       QUERY_READY,
  input  logic       QUERY_DONE,
  input  logic       QUERY_HIT,
  output logic [7:0] FOOD_HORZ,
  output logic [6:0] FOOD_VERT,
  output logic       BUSY,
  output logic       PLACED,
  output logic       FIELD_FULL
);

  localparam logic [7:0]  H_LAST    = 8'(H_MAX - 1);
  localparam logic [6:0]  V_LAST    = 7'(V_MAX - 1);
  localparam logic [14:0] AREA      = 15'(H_MAX * V_MAX);
  localparam logic [7:0]  TRIES_LIM = 8'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_QUERY,
    S_WAIT,
    S_SCAN_STEP,
    S_COMMIT
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  prev_ms_q;
  logic        pending_q, pending_d;
  logic [7:0]  cand_h_q, cand_h_d;
  logic [6:0]  cand_v_q, cand_v_d;
  logic [7:0]  last_h_q, last_h_d;
  logic [6:0]  last_v_q, last_v_d;
  logic [7:0]  tries_q, tries_d;
  logic [14:0] scan_q, scan_d;
  logic        raster_q, raster_d;
  logic [7:0]  food_h_q, food_h_d;
  logic [6:0]  food_v_q, food_v_d;
  logic        full_q, full_d;

  logic        trigger;
  logic        rand_in_range;
  logic        fail_try;

  // A placement is requested by REQ or by the game entering its running state.
  assign trigger       = REQ | ((prev_ms_q == 2'b00) && (MASTER_STATE == 2'b01));
  assign rand_in_range = (RAND_HORZ <= H_LAST) && (RAND_VERT <= V_LAST);

  // Next-state, candidate selection and retry/raster bookkeeping.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cand_h_d  = cand_h_q;
    cand_v_d  = cand_v_q;
    last_h_d  = last_h_q;
    last_v_d  = last_v_q;
    tries_d   = tries_q;
    scan_d    = scan_q;
    raster_d  = raster_q;
    food_h_d  = food_h_q;
    food_v_d  = food_v_q;
    full_d    = full_q;
    fail_try  = 1'b0;

    // Only one request can be remembered while a placement is in flight.
    if (trigger && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tries_d  = '0;
        scan_d   = '0;
        raster_d = 1'b0;
        last_h_d = '0;
        last_v_d = '0;
        if (trigger || pending_q) begin
          pending_d = 1'b0;
          state_d   = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        cand_h_d = RAND_HORZ;
        cand_v_d = RAND_VERT;
        tries_d  = tries_q + 8'd1;
        if (rand_in_range) begin
          last_h_d = RAND_HORZ;
          last_v_d = RAND_VERT;
          state_d  = S_QUERY;
        end else begin
          fail_try = 1'b1;
        end
      end
      S_QUERY: begin
        if (QUERY_READY) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (QUERY_DONE) begin
          if (!QUERY_HIT) begin
            state_d = S_COMMIT;
          end else if (raster_q) begin
            if (scan_q == AREA) begin
              full_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_SCAN_STEP;
            end
          end else begin
            fail_try = 1'b1;
          end
        end
      end
      S_SCAN_STEP: begin
        if (cand_h_q >= H_LAST) begin
          cand_h_d = '0;
          cand_v_d = (cand_v_q >= V_LAST) ? 7'd0 : cand_v_q + 7'd1;
        end else begin
          cand_h_d = cand_h_q + 8'd1;
        end
        scan_d  = scan_q + 15'd1;
        state_d = S_QUERY;
      end
      S_COMMIT: begin
        food_h_d = cand_h_q;
        food_v_d = cand_v_q;
        full_d   = 1'b0;
        tries_d  = '0;
        scan_d   = '0;
        raster_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A rejected random try either retries or switches to the raster scan,
    // which starts from the last legal candidate (or the origin).
    if (fail_try) begin
      if (tries_d < TRIES_LIM) begin
        state_d = S_SAMPLE;
      end else begin
        raster_d = 1'b1;
        cand_h_d = last_h_q;
        cand_v_d = last_v_q;
        state_d  = S_SCAN_STEP;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      prev_ms_q <= 2'b00;
      pending_q <= 1'b0;
      cand_h_q  <= '0;
      cand_v_q  <= '0;
      last_h_q  <= '0;
      last_v_q  <= '0;
      tries_q   <= '0;
      scan_q    <= '0;
      raster_q  <= 1'b0;
      food_h_q  <= 8'd30;
      food_v_q  <= 7'd20;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_ms_q <= MASTER_STATE;
      pending_q <= pending_d;
      cand_h_q  <= cand_h_d;
      cand_v_q  <= cand_v_d;
      last_h_q  <= last_h_d;
      last_v_q  <= last_v_d;
      tries_q   <= tries_d;
      scan_q    <= scan_d;
      raster_q  <= raster_d;
      food_h_q  <= food_h_d;
      food_v_q  <= food_v_d;
      full_q    <= full_d;
    end
  end

  assign QUERY_VALID = (state_q == S_QUERY);
  assign QUERY_HORZ  = cand_h_q;
  assign QUERY_VERT  = cand_v_q;
  assign BUSY        = (state_q != S_IDLE);
  assign PLACED      = (state_q == S_COMMIT);
  assign FOOD_HORZ   = food_h_q;
  assign FOOD_VERT   = food_v_q;
  assign FIELD_FULL  = full_q;

endmodule
